instruction_decoder: RTL and testbench

INSTRUCTION_DECODER -- requirements
Module: instruction_decoder

---
 rtl/instruction_decoder.sv | 141 ++++++++++++++
 tb/tb_instruction_decoder.sv | 123 ++++++++++++
 2 files changed

// File: rtl/instruction_decoder.sv
// instruction_decoder: registered RV32I decoder with one-hot op flags and raw field slices.
// Define DECODER_CUST_OP_EN to decode opcode 1111111 as cust_op; otherwise it is invalid.
module instruction_decoder (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instruction_code,
    input  logic        en,
    output logic        invalid_instruction,
    output logic [20:0] alu_op,
    output logic [7:0]  jmp_op,
    output logic [7:0]  mem_op,
    output logic [5:0]  csr_op,
    output logic [3:0]  mechie_op,
    output logic        cust_op,
    output logic [4:0]  rd,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [6:0]  imm_2531,
    output logic [19:0] imm_1231,
    output logic [11:0] imm_2032
);
    logic [6:0]  opc, f7;
    logic [2:0]  f3;
    logic        op_imm, op_reg, op_br, op_ld, op_st, op_sys, f7_z, f7_alt;
    logic [20:0] alu_op_d, alu_op_q;
    logic [7:0]  jmp_op_d, jmp_op_q, mem_op_d, mem_op_q;
    logic [5:0]  csr_op_d, csr_op_q;
    logic [3:0]  mechie_op_d, mechie_op_q;
    logic        cust_op_d, cust_op_q, invalid_d, invalid_q;
    logic [31:7] instr_d, instr_q;

    assign opc    = instruction_code[6:0];
    assign f3     = instruction_code[14:12];
    assign f7     = instruction_code[31:25];
    assign op_imm = opc == 7'b0010011;
    assign op_reg = opc == 7'b0110011;
    assign op_br  = opc == 7'b1100011;
    assign op_ld  = opc == 7'b0000011;
    assign op_st  = opc == 7'b0100011;
    assign op_sys = opc == 7'b1110011;
    assign f7_z   = f7 == 7'b0000000;
    assign f7_alt = f7 == 7'b0100000;

    always_comb begin
        alu_op_d     = '0;
        jmp_op_d     = '0;
        mem_op_d     = '0;
        csr_op_d     = '0;
        mechie_op_d  = '0;
        cust_op_d    = 1'b0;
        instr_d      = instruction_code[31:7];
        alu_op_d[0]  = opc == 7'b0110111;
        alu_op_d[1]  = opc == 7'b0010111;
        alu_op_d[2]  = op_imm && f3 == 3'b000;
        alu_op_d[3]  = op_imm && f3 == 3'b010;
        alu_op_d[4]  = op_imm && f3 == 3'b011;
        alu_op_d[5]  = op_imm && f3 == 3'b100;
        alu_op_d[6]  = op_imm && f3 == 3'b110;
        alu_op_d[7]  = op_imm && f3 == 3'b111;
        alu_op_d[8]  = op_imm && f3 == 3'b001 && f7_z;
        alu_op_d[9]  = op_imm && f3 == 3'b101 && f7_z;
        alu_op_d[10] = op_imm && f3 == 3'b101 && f7_alt;
        alu_op_d[11] = op_reg && f3 == 3'b000 && f7_z;
        alu_op_d[12] = op_reg && f3 == 3'b000 && f7_alt;
        alu_op_d[13] = op_reg && f3 == 3'b001 && f7_z;
        alu_op_d[14] = op_reg && f3 == 3'b010 && f7_z;
        alu_op_d[15] = op_reg && f3 == 3'b011 && f7_z;
        alu_op_d[16] = op_reg && f3 == 3'b100 && f7_z;
        alu_op_d[17] = op_reg && f3 == 3'b101 && f7_z;
        alu_op_d[18] = op_reg && f3 == 3'b101 && f7_alt;
        alu_op_d[19] = op_reg && f3 == 3'b110 && f7_z;
        alu_op_d[20] = op_reg && f3 == 3'b111 && f7_z;
        jmp_op_d[0]  = opc == 7'b1101111;
        jmp_op_d[1]  = opc == 7'b1100111 && f3 == 3'b000;
        jmp_op_d[2]  = op_br && f3 == 3'b000;
        jmp_op_d[3]  = op_br && f3 == 3'b001;
        jmp_op_d[4]  = op_br && f3 == 3'b100;
        jmp_op_d[5]  = op_br && f3 == 3'b101;
        jmp_op_d[6]  = op_br && f3 == 3'b110;
        jmp_op_d[7]  = op_br && f3 == 3'b111;
        mem_op_d[0]  = op_ld && f3 == 3'b000;
        mem_op_d[1]  = op_ld && f3 == 3'b001;
        mem_op_d[2]  = op_ld && f3 == 3'b010;
        mem_op_d[3]  = op_ld && f3 == 3'b100;
        mem_op_d[4]  = op_ld && f3 == 3'b101;
        mem_op_d[5]  = op_st && f3 == 3'b000;
        mem_op_d[6]  = op_st && f3 == 3'b001;
        mem_op_d[7]  = op_st && f3 == 3'b010;
        csr_op_d[0]  = op_sys && f3 == 3'b001;
        csr_op_d[1]  = op_sys && f3 == 3'b010;
        csr_op_d[2]  = op_sys && f3 == 3'b011;
        csr_op_d[3]  = op_sys && f3 == 3'b101;
        csr_op_d[4]  = op_sys && f3 == 3'b110;
        csr_op_d[5]  = op_sys && f3 == 3'b111;
        mechie_op_d[0] = opc == 7'b0001111 && f3 == 3'b000;
        mechie_op_d[1] = instruction_code == 32'h0000_0073;
        mechie_op_d[2] = instruction_code == 32'h0010_0073;
        mechie_op_d[3] = instruction_code == 32'h3020_0073;
`ifdef DECODER_CUST_OP_EN
        cust_op_d    = opc == 7'b1111111;
`endif
        invalid_d    = ~|{alu_op_d, jmp_op_d, mem_op_d, csr_op_d, mechie_op_d, cust_op_d};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_op_q    <= '0;
            jmp_op_q    <= '0;
            mem_op_q    <= '0;
            csr_op_q    <= '0;
            mechie_op_q <= '0;
            cust_op_q   <= 1'b0;
            invalid_q   <= 1'b0;
            instr_q     <= '0;
        end else if (en) begin
            alu_op_q    <= alu_op_d;
            jmp_op_q    <= jmp_op_d;
            mem_op_q    <= mem_op_d;
            csr_op_q    <= csr_op_d;
            mechie_op_q <= mechie_op_d;
            cust_op_q   <= cust_op_d;
            invalid_q   <= invalid_d;
            instr_q     <= instr_d;
        end
    end

    // Field outputs are slices of the registered word, so they match the registered decode.
    assign invalid_instruction = invalid_q;
    assign alu_op    = alu_op_q;
    assign jmp_op    = jmp_op_q;
    assign mem_op    = mem_op_q;
    assign csr_op    = csr_op_q;
    assign mechie_op = mechie_op_q;
    assign cust_op   = cust_op_q;
    assign rd        = instr_q[11:7];
    assign rs1       = instr_q[19:15];
    assign rs2       = instr_q[24:20];
    assign imm_2531  = instr_q[31:25];
    assign imm_1231  = instr_q[31:12];
    assign imm_2032  = instr_q[31:20];
endmodule

// File: tb/tb_instruction_decoder.sv
// tb_instruction_decoder: directed-vector bench for instruction_decoder using immediate assertions.
module tb_instruction_decoder;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] instruction_code = '0;
    logic        en = 1'b0;
    logic        invalid_instruction, cust_op;
    logic [20:0] alu_op;
    logic [7:0]  jmp_op, mem_op;
    logic [5:0]  csr_op;
    logic [3:0]  mechie_op;
    logic [4:0]  rd, rs1, rs2;
    logic [6:0]  imm_2531;
    logic [19:0] imm_1231;
    logic [11:0] imm_2032;
    logic [47:0] flags;
    logic [102:0] all_out;
    logic [102:0] held;
    int errors = 0;
    int checks = 0;

    instruction_decoder dut (
        .clk(clk), .rst_n(rst_n), .instruction_code(instruction_code), .en(en),
        .invalid_instruction(invalid_instruction), .alu_op(alu_op), .jmp_op(jmp_op),
        .mem_op(mem_op), .csr_op(csr_op), .mechie_op(mechie_op), .cust_op(cust_op),
        .rd(rd), .rs1(rs1), .rs2(rs2), .imm_2531(imm_2531), .imm_1231(imm_1231),
        .imm_2032(imm_2032)
    );

    always #5 clk = ~clk;

    // Flag bit positions: alu 0-20, jmp 21-28, mem 29-36, csr 37-42, mechie 43-46, cust 47.
    assign flags   = {cust_op, mechie_op, csr_op, mem_op, jmp_op, alu_op};
    assign all_out = {invalid_instruction, flags, rd, rs1, rs2, imm_2531, imm_1231, imm_2032};

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic [31:0] w, input logic e);
        @(negedge clk);
        instruction_code = w;
        en = e;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_op(input string tag, input logic [31:0] w, input int bit_idx, input logic inv);
        step(w, 1'b1);
        chk({tag, "_flags"}, 128'(flags), inv ? 128'd0 : (128'd1 << bit_idx));
        chk({tag, "_invalid"}, 128'(invalid_instruction), 128'(inv));
    endtask

    initial begin
        #1;
        chk("reset_all_zero", 128'(all_out), 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step(32'h0000_0000, 1'b1);
        chk("zero_invalid", 128'(invalid_instruction), 128'd1);
        chk("zero_flags", 128'(flags), 128'd0);
        chk_op("auipc", 32'h0000_0797, 1, 1'b0);
        chk("auipc_rd", 128'(rd), 128'd15);
        chk("auipc_imm", 128'(imm_1231), 128'h0);
        chk_op("addi", 32'h02C7_8793, 2, 1'b0);
        chk("addi_fields", 128'({rd, rs1, imm_2032}), 128'({5'd15, 5'd15, 12'h02C}));
        chk_op("ori", 32'h07F5_6513, 6, 1'b0);
        chk("ori_fields", 128'({rd, rs1, imm_2032}), 128'({5'd10, 5'd10, 12'h07F}));
        chk_op("csrrw", 32'h3057_93F3, 37, 1'b0);
        chk("csrrw_fields", 128'({rd, rs1, imm_2032}), 128'({5'd7, 5'd15, 12'h305}));
        chk_op("jal", 32'h1A50_00EF, 21, 1'b0);
        chk("jal_rd", 128'(rd), 128'd1);
        chk_op("sw", 32'h0011_2623, 36, 1'b0);
        chk("sw_regs", 128'({rs1, rs2}), 128'({5'd2, 5'd1}));
        chk_op("bne", 32'h0407_9263, 24, 1'b0);
        chk("bne_regs", 128'({rs1, rs2}), 128'({5'd15, 5'd0}));
        chk_op("mret", 32'h3020_0073, 46, 1'b0);
        chk_op("ecall", 32'h0000_0073, 44, 1'b0);
        chk_op("ebreak", 32'h0010_0073, 45, 1'b0);
        chk_op("fence", 32'h0000_000F, 43, 1'b0);
        chk_op("srai", 32'h4000_5013, 10, 1'b0);
        chk_op("srli", 32'h0000_5013, 9, 1'b0);
        chk_op("srai_bad_f7", 32'h2000_5013, 0, 1'b1);
        chk_op("sub", 32'h4000_0033, 12, 1'b0);
        chk_op("sra", 32'h4000_5033, 18, 1'b0);
        chk_op("sll_bad_f7", 32'h4000_1033, 0, 1'b1);
        chk_op("csr_f3_000", 32'h0000_00F3, 0, 1'b1);
        chk_op("load_f3_011", 32'h0000_3003, 0, 1'b1);
        chk_op("lhu", 32'h0000_5003, 33, 1'b0);
        chk_op("and", 32'h0000_7033, 20, 1'b0);
`ifdef DECODER_CUST_OP_EN
        chk_op("custom", 32'h8000_007F, 47, 1'b0);
`else
        chk_op("custom", 32'h8000_007F, 0, 1'b1);
`endif
        chk("custom_imm", 128'({imm_2531, rd}), 128'({7'h40, 5'd0}));
        held = all_out;
        step(32'h0000_0797, 1'b0);
        chk("hold_en0", 128'(all_out), 128'(held));
        step(32'h02C7_8793, 1'b1);
        chk("before_async_reset", 128'(alu_op), 128'd4);
        @(negedge clk);
        instruction_code = 32'h0000_0797;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset", 128'(all_out), 128'd0);
        @(posedge clk);
        #1;
        chk("pending_discarded", 128'(all_out), 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step(32'h0011_2623, 1'b1);
        chk("post_reset_decode", 128'(flags), 128'd1 << 36);
        chk("post_reset_valid", 128'(invalid_instruction), 128'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
